// File: rtl/seq_signed_divider.sv
// Restoring signed divider, one quotient bit per clock; done pulses WIDTH+1 edges after the accepting edge.
// Start is taken only while ready; start during a division is ignored and results hold until the next done.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_dvs_q, zero_dvs_d;
  logic             min_neg1_q, min_neg1_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   trial_shift;
  logic [WIDTH:0]   trial_diff;
  logic [WIDTH-1:0] min_val;

  always_comb begin
    min_val      = {1'b1, {(WIDTH-1){1'b0}}};
    // Negating MIN yields 2^(WIDTH-1) as an unsigned magnitude, which is exactly what we want.
    dividend_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    trial_shift  = {rem_q, acc_q[WIDTH-1]};
    trial_diff   = trial_shift - {1'b0, dvs_q};

    state_d       = state_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    dvs_d         = dvs_q;
    dvd_raw_d     = dvd_raw_q;
    cnt_d         = cnt_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_dvs_d    = zero_dvs_q;
    min_neg1_d    = min_neg1_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d      = '0;
          acc_d      = dividend_mag;
          dvs_d      = divisor_mag;
          dvd_raw_d  = dividend;
          cnt_d      = CW'(WIDTH);
          neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
          zero_dvs_d = (divisor == '0);
          min_neg1_d = (dividend == min_val) && (divisor == '1);
          state_d    = S_BUSY;
        end
      end

      S_BUSY: begin
        if (!trial_diff[WIDTH]) begin
          rem_d = trial_diff[WIDTH-1:0];
          acc_d = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial_shift[WIDTH-1:0];
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Divide-by-zero bypasses the iterated values; MIN/-1 wraps naturally in the negation.
        if (zero_dvs_q) begin
          quotient_d  = '1;
          remainder_d = dvd_raw_q;
        end else begin
          quotient_d  = neg_quo_q ? (~acc_q + WIDTH'(1)) : acc_q;
          remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
        end
        div_by_zero_d = zero_dvs_q;
        overflow_d    = min_neg1_q;
        done_d        = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      acc_q         <= '0;
      dvs_q         <= '0;
      dvd_raw_q     <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      zero_dvs_q    <= 1'b0;
      min_neg1_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      acc_q         <= acc_d;
      dvs_q         <= dvs_d;
      dvd_raw_q     <= dvd_raw_d;
      cnt_q         <= cnt_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      zero_dvs_q    <= zero_dvs_d;
      min_neg1_q    <= min_neg1_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed corner cases, start-ignore, reset abort, random and back-to-back runs.
module tb_seq_signed_divider;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia;
    int   ib;
    ia = $signed(a);
    ib = $signed(b);
    if (ib == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
      e.ov = 1'b0;
    end else begin
      e.q  = W'(ia / ib);
      e.r  = W'(ia % ib);
      e.dz = 1'b0;
      e.ov = (ia == -(1 << (W - 1))) && (ib == -1);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 40) begin
      tick();
      lat++;
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d edges", lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if ({quotient, remainder} !== '0) begin
      errors++; $display("FAIL reset_results: got q=%h r=%h want 0", quotient, remainder);
    end
    checks++;
    if ({div_by_zero, overflow} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got dz=%b ov=%b want 0", div_by_zero, overflow);
    end
  endtask

  task automatic test_directed();
    int         da[6]  = '{100, -100, 100, 7, -128, -128};
    int         db[6]  = '{7, 7, -7, 0, -1, 1};
    logic [7:0] eq[6]  = '{8'h0E, 8'hF2, 8'hF2, 8'hFF, 8'h80, 8'h80};
    logic [7:0] er[6]  = '{8'h02, 8'hFE, 8'h02, 8'h07, 8'h00, 8'h00};
    logic       edz[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eov[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t       e;
    exp_t       held;
    int         lat;
    logic       ok;
    for (int i = 0; i < 6; i++) begin
      launch(W'(da[i]), W'(db[i]));
      sb.push_back('{q: eq[i], r: er[i], dz: edz[i], ov: eov[i]});
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++;
      if (lat !== W + 1) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d edges want %0d", i, lat, W + 1);
      end
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
        errors++;
        $display("FAIL directed_result[%0d] %0d/%0d: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                 i, da[i], db[i], quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
      end
    end
    held = '{q: eq[5], r: er[5], dz: edz[5], ov: eov[5]};
    dividend = 8'h33;
    divisor  = 8'h05;
    repeat (3) tick();
    checks++;
    if ({done, quotient, remainder, div_by_zero, overflow} !== {1'b0, held.q, held.r, held.dz, held.ov}) begin
      errors++;
      $display("FAIL result_hold: got done=%b q=%h r=%h want done=0 q=%h r=%h", done, quotient, remainder,
               held.q, held.r);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    logic ok;
    launch(8'd100, 8'd7);
    sb.push_back(model(8'd100, 8'd7));
    tick();
    tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", ready); end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (lat !== W - 2) begin
      errors++; $display("FAIL ignore_latency: got %0d edges after E3 want %0d", lat, W - 2);
    end
    checks++;
    if ({quotient, remainder} !== {e.q, e.r}) begin
      errors++; $display("FAIL ignore_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
    lat = 0;
    repeat (W + 4) begin
      tick();
      if (done) lat++;
    end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d pulses want 0", lat); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    launch(8'd100, 8'd7);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++; $display("FAIL abort_handshake: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== '0) begin
      errors++; $display("FAIL abort_outputs: got q=%h r=%h dz=%b ov=%b want 0", quotient, remainder,
                         div_by_zero, overflow);
    end
    pulses = 0;
    repeat (W + 6) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_random();
    exp_t         e;
    int           lat;
    logic         ok;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 5 == 0) a = 8'h80;
      if (i % 7 == 3) b = 8'h00;
      if (i % 6 == 2) b = 8'hFF;
      launch(a, b);
      sb.push_back(model(a, b));
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++;
      if (lat !== W + 1) begin
        errors++; $display("FAIL random_latency[%0d]: got %0d edges want %0d", i, lat, W + 1);
      end
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
        errors++;
        $display("FAIL random_result[%0d] %h/%h: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                 i, a, b, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [W-1:0] opa[N];
    logic [W-1:0] opb[N];
    exp_t         e;
    int           acc;
    int           got;
    int           last_acc;
    int           cyc;
    bit           take;
    for (int i = 0; i < N; i++) begin
      opa[i] = W'($urandom);
      opb[i] = W'($urandom_range(1, 255));
    end
    acc      = 0;
    got      = 0;
    last_acc = -1;
    cyc      = 0;
    dividend = opa[0];
    divisor  = opb[0];
    start    = 1'b1;
    while (got < N && cyc < 300) begin
      take = ready && (acc < N);
      if (take) sb.push_back(model(dividend, divisor));
      tick();
      cyc++;
      if (take) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== W + 2) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got %0d edges want %0d", acc, cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        acc++;
        if (acc < N) begin
          dividend = opa[acc];
          divisor  = opb[acc];
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b2b_unexpected_done: got done with empty scoreboard want none");
        end else begin
          e = sb.pop_front();
          checks++;
          if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got q=%h r=%h want q=%h r=%h", got, quotient, remainder, e.q, e.r);
          end
        end
        got++;
      end
    end
    start = 1'b0;
    if (got < N) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout: got %0d results want %0d", got, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
